// File: rtl/floo_sl_credit_arbiter.sv
// Two-VC credit-based arbiter that merges the request and response flit streams
// into one registered output stream toward a serial link.
module floo_sl_credit_arbiter #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NumCredits = 8,
  parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DataWidth-1:0] req_data_i,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [DataWidth-1:0] rsp_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_vc_o,
  input  logic                 credit_req_i,
  input  logic                 credit_rsp_i,
  output logic [CntWidth-1:0]  credits_req_o,
  output logic [CntWidth-1:0]  credits_rsp_o,
  output logic                 credit_err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 out_vc_q, out_vc_d;
  logic [CntWidth-1:0]  cnt_req_q, cnt_req_d;
  logic [CntWidth-1:0]  cnt_rsp_q, cnt_rsp_d;
  logic                 err_q, err_d;
  logic                 rr_q, rr_d;

  logic free, req_elig, rsp_elig, gnt_req, gnt_rsp;
  logic req_ovf, rsp_ovf;

  // A credit arriving this cycle is not visible until the counter updates.
  assign free     = rst_ni && (!out_valid_q || out_ready_i);
  assign req_elig = req_valid_i && (cnt_req_q != '0);
  assign rsp_elig = rsp_valid_i && (cnt_rsp_q != '0);
  assign gnt_req  = free && req_elig && (!rsp_elig || !rr_q);
  assign gnt_rsp  = free && rsp_elig && (!req_elig || rr_q);

  assign req_ovf = credit_req_i && !gnt_req && (cnt_req_q == MaxCnt);
  assign rsp_ovf = credit_rsp_i && !gnt_rsp && (cnt_rsp_q == MaxCnt);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_vc_d    = out_vc_q;
    rr_d        = rr_q;
    cnt_req_d   = cnt_req_q;
    cnt_rsp_d   = cnt_rsp_q;
    err_d       = err_q || req_ovf || rsp_ovf;

    if (gnt_req) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data_i;
      out_vc_d    = 1'b0;
    end else if (gnt_rsp) begin
      out_valid_d = 1'b1;
      out_data_d  = rsp_data_i;
      out_vc_d    = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // Pointer only moves when both VCs competed for a free output.
    if (free && req_elig && rsp_elig) begin
      rr_d = ~rr_q;
    end

    if (gnt_req && !credit_req_i) begin
      cnt_req_d = cnt_req_q - 1'b1;
    end else if (credit_req_i && !gnt_req && !req_ovf) begin
      cnt_req_d = cnt_req_q + 1'b1;
    end

    if (gnt_rsp && !credit_rsp_i) begin
      cnt_rsp_d = cnt_rsp_q - 1'b1;
    end else if (credit_rsp_i && !gnt_rsp && !rsp_ovf) begin
      cnt_rsp_d = cnt_rsp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vc_q    <= 1'b0;
      cnt_req_q   <= MaxCnt;
      cnt_rsp_q   <= MaxCnt;
      err_q       <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
      cnt_req_q   <= cnt_req_d;
      cnt_rsp_q   <= cnt_rsp_d;
      err_q       <= err_d;
      rr_q        <= rr_d;
    end
  end

  assign req_ready_o   = gnt_req;
  assign rsp_ready_o   = gnt_rsp;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_vc_o      = out_vc_q;
  assign credits_req_o = cnt_req_q;
  assign credits_rsp_o = cnt_rsp_q;
  assign credit_err_o  = err_q;

endmodule

// File: tb/tb_floo_sl_credit_arbiter.sv
// Directed, table-driven bench for floo_sl_credit_arbiter with NumCredits=8.
module tb_floo_sl_credit_arbiter;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned CntWidth  = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 req_valid_i, req_ready_o;
  logic [DataWidth-1:0] req_data_i;
  logic                 rsp_valid_i, rsp_ready_o;
  logic [DataWidth-1:0] rsp_data_i;
  logic                 out_valid_o, out_ready_i;
  logic [DataWidth-1:0] out_data_o;
  logic                 out_vc_o;
  logic                 credit_req_i, credit_rsp_i;
  logic [CntWidth-1:0]  credits_req_o, credits_rsp_o;
  logic                 credit_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  floo_sl_credit_arbiter #(
    .DataWidth (DataWidth),
    .NumCredits(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_ready_o  (rsp_ready_o),
    .rsp_data_i   (rsp_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_vc_o     (out_vc_o),
    .credit_req_i (credit_req_i),
    .credit_rsp_i (credit_rsp_i),
    .credits_req_o(credits_req_o),
    .credits_rsp_o(credits_rsp_o),
    .credit_err_o (credit_err_o)
  );

  typedef struct {
    logic       req_v, rsp_v, out_rdy, cr_req, cr_rsp;
    logic [7:0] req_d, rsp_d;
    logic       e_req_rdy, e_rsp_rdy, e_val, e_vc;
    logic [7:0] e_data;
    logic [3:0] e_creq, e_crsp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic sv, input logic ordy,
                       input logic cq, input logic cs,
                       input logic [7:0] rd, input logic [7:0] sd);
    req_valid_i  = rv;
    rsp_valid_i  = sv;
    out_ready_i  = ordy;
    credit_req_i = cq;
    credit_rsp_i = cs;
    req_data_i   = DataWidth'(rd);
    rsp_data_i   = DataWidth'(sd);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_out_vc", out_vc_o, 0);
    chk("rst_cnt_req", credits_req_o, 8);
    chk("rst_cnt_rsp", credits_rsp_o, 8);
    chk("rst_err", credit_err_o, 0);

    // Vector table: arbitration, pointer, backpressure, credit accounting.
    vecs[0] = '{1,1,1,0,0, 8'h11,8'h22, 1,0, 1,0, 8'h11, 4'd7,4'd8};
    vecs[1] = '{1,1,1,0,0, 8'h13,8'h24, 0,1, 1,1, 8'h24, 4'd7,4'd7};
    vecs[2] = '{1,0,1,0,0, 8'h33,8'h00, 1,0, 1,0, 8'h33, 4'd6,4'd7};
    vecs[3] = '{0,1,1,0,0, 8'h00,8'h44, 0,1, 1,1, 8'h44, 4'd6,4'd6};
    vecs[4] = '{0,0,1,1,0, 8'h00,8'h00, 0,0, 0,0, 8'h00, 4'd7,4'd6};
    vecs[5] = '{1,1,0,0,0, 8'h55,8'h66, 1,0, 1,0, 8'h55, 4'd6,4'd6};
    vecs[6] = '{1,1,0,0,1, 8'h57,8'h68, 0,0, 1,0, 8'h55, 4'd6,4'd7};
    vecs[7] = '{1,1,1,0,0, 8'h77,8'h88, 0,1, 1,1, 8'h88, 4'd6,4'd6};
    vecs[8] = '{1,0,1,1,0, 8'h99,8'h00, 1,0, 1,0, 8'h99, 4'd6,4'd6};
    vecs[9] = '{0,0,1,0,0, 8'h00,8'h00, 0,0, 0,0, 8'h00, 4'd6,4'd6};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].req_v, vecs[i].rsp_v, vecs[i].out_rdy, vecs[i].cr_req, vecs[i].cr_rsp,
            vecs[i].req_d, vecs[i].rsp_d);
      #1;
      chk($sformatf("v%0d_req_rdy", i), req_ready_o, vecs[i].e_req_rdy);
      chk($sformatf("v%0d_rsp_rdy", i), rsp_ready_o, vecs[i].e_rsp_rdy);
      tick();
      chk($sformatf("v%0d_valid", i), out_valid_o, vecs[i].e_val);
      if (vecs[i].e_val) begin
        chk($sformatf("v%0d_vc", i), out_vc_o, vecs[i].e_vc);
        chk($sformatf("v%0d_data", i), out_data_o, 64'(vecs[i].e_data));
      end
      chk($sformatf("v%0d_cnt_req", i), credits_req_o, vecs[i].e_creq);
      chk($sformatf("v%0d_cnt_rsp", i), credits_rsp_o, vecs[i].e_crsp);
      chk($sformatf("v%0d_err", i), credit_err_o, 0);
    end

    // Credit exhaustion: exactly 8 consecutive req flits.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 1, 0, 0, 8'(i), 8'h00);
      #1;
      chk($sformatf("exh_rdy%0d", i), req_ready_o, (i < 8) ? 1'b1 : 1'b0);
      tick();
    end
    chk("exh_cnt_req", credits_req_o, 0);

    // Both VCs streaming: VC alternates starting with req.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 1, 0, 0, 8'h10, 8'h20);
      tick();
      chk($sformatf("rr_vc%0d", i), out_vc_o, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("rr_valid%0d", i), out_valid_o, 1);
    end

    // Backpressure hold then bubble-free release.
    do_reset();
    drive(1, 0, 1, 0, 0, 8'hA5, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 8'hB6, 8'hC7);
      #1;
      chk($sformatf("bp_req_rdy%0d", i), req_ready_o, 0);
      chk($sformatf("bp_rsp_rdy%0d", i), rsp_ready_o, 0);
      tick();
      chk($sformatf("bp_data%0d", i), out_data_o, 64'hA5);
      chk($sformatf("bp_vc%0d", i), out_vc_o, 0);
      chk($sformatf("bp_valid%0d", i), out_valid_o, 1);
    end
    drive(1, 1, 1, 0, 0, 8'hB6, 8'hC7);
    #1;
    chk("bp_rel_rdy", req_ready_o, 1);
    tick();
    chk("bp_rel_valid", out_valid_o, 1);
    chk("bp_rel_data", out_data_o, 64'hB6);

    // Credit arriving at zero count is usable only next cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 0, 0, 8'h00, 8'(i));
      tick();
    end
    chk("zc_cnt0", credits_rsp_o, 0);
    drive(0, 1, 1, 0, 1, 8'h00, 8'h5A);
    #1;
    chk("zc_no_grant", rsp_ready_o, 0);
    tick();
    chk("zc_cnt1", credits_rsp_o, 1);
    drive(0, 1, 1, 0, 0, 8'h00, 8'h5B);
    #1;
    chk("zc_grant", rsp_ready_o, 1);
    tick();
    chk("zc_cnt_back0", credits_rsp_o, 0);
    chk("zc_data", out_data_o, 64'h5B);

    // Overflow is sticky until reset.
    do_reset();
    drive(0, 0, 1, 1, 0, 8'h00, 8'h00);
    tick();
    chk("ovf_cnt", credits_req_o, 8);
    chk("ovf_err", credit_err_o, 1);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    chk("ovf_sticky", credit_err_o, 1);

    // Reset mid-operation with counters 3/5 and a flit held.
    do_reset();
    chk("ovf_cleared", credit_err_o, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 0, 8'h31, 8'h00);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 8'h00, 8'h42);
      tick();
    end
    chk("mid_cnt_req", credits_req_o, 3);
    chk("mid_cnt_rsp", credits_rsp_o, 5);
    chk("mid_valid", out_valid_o, 1);
    rst_ni = 1'b0;
    drive(1, 1, 1, 1, 1, 8'h77, 8'h88);
    #1;
    chk("mid_rst_req_rdy", req_ready_o, 0);
    chk("mid_rst_rsp_rdy", rsp_ready_o, 0);
    tick();
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_cnt_req", credits_req_o, 8);
    chk("mid_rst_cnt_rsp", credits_rsp_o, 8);
    chk("mid_rst_err", credit_err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
